// File: rtl/mux_nto1_stream.sv
// mux_nto1_stream
//
// Registered N:1 stream multiplexer. Each of N producer channels offers a
// word with a valid/ready handshake. One channel is granted per cycle and its
// word goes into a single-entry output register, which also drives a
// valid/ready handshake towards one shared consumer.
//
// The channel is picked in one of two ways:
//   mode = 0 : fixed select. The channel named by sel is used. A sel >= N
//              selects nothing.
//   mode = 1 : round-robin. The first requesting channel is used, searching
//              from ptr upwards and wrapping past N-1 back to 0. After each
//              round-robin grant, ptr moves to the channel just above the
//              granted one.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    N*W  channel c occupies bits [c*W +: W]
//   in_valid   N    channel c has a word available
//   in_ready   N    channel c word is taken this cycle (combinational, one-hot or 0)
//   mode       1    0 = fixed select, 1 = round-robin
//   sel        SEL_W channel index used in fixed mode
//   out_data   W    registered selected word
//   out_ch     SEL_W registered index of the channel that supplied out_data
//   out_valid  1    out_data/out_ch hold a word
//   out_ready  1    consumer accepts the word this cycle
//
// Parameters must satisfy 2 <= N <= 2**SEL_W.

module mux_nto1_stream #(
    parameter int N     = 16,
    parameter int W     = 8,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_ch,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [W-1:0]     out_data_reg;
    logic [SEL_W-1:0] out_ch_reg;
    logic             out_valid_reg;
    logic [SEL_W-1:0] ptr_reg;

    logic             ld;
    logic [N-1:0]     fixed_grant;
    logic [N-1:0]     upper_mask;
    logic [N-1:0]     upper_req;
    logic [N-1:0]     upper_first;
    logic [N-1:0]     any_first;
    logic [N-1:0]     rr_grant;
    logic [N-1:0]     grant;
    logic             any_grant;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] ptr_next;
    logic [W-1:0]     data_next;

    // The output register can take a new word when it is empty or when its
    // current word leaves this same cycle (no bubble on back-to-back traffic).
    assign ld = !out_valid_reg || out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            // Only indices below N exist, so an out-of-range sel matches nothing.
            assign fixed_grant[gi] = in_valid[gi] && (sel == SEL_W'(gi));
            // Channels at or above the pointer form the first half of the
            // circular search.
            assign upper_mask[gi]  = (SEL_W'(gi) >= ptr_reg);
        end
    endgenerate

    // Circular priority search: take the lowest requester at or above ptr,
    // otherwise the lowest requester overall (the wrapped-around part).
    // x & (~x + 1) isolates the lowest set bit of x.
    assign upper_req   = in_valid & upper_mask;
    assign upper_first = upper_req & (~upper_req + N'(1));
    assign any_first   = in_valid & (~in_valid + N'(1));
    assign rr_grant    = (|upper_req) ? upper_first : any_first;

    assign grant     = mode ? rr_grant : fixed_grant;
    assign any_grant = |grant;

    // grant is one-hot or zero, so this encodes the index and picks the data.
    always_comb begin
        grant_idx = '0;
        data_next = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx = SEL_W'(i);
                data_next = in_data[i*W +: W];
            end
        end
    end

    assign ptr_next = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + SEL_W'(1);

    // in_ready is held low while reset is asserted. The output register
    // cannot capture during reset, so a word handed over then would be lost.
    assign in_ready = (rst_n && ld) ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            out_valid_reg <= 1'b0;
            ptr_reg       <= '0;
        end else if (ld) begin
            if (any_grant) begin
                out_data_reg  <= data_next;
                out_ch_reg    <= grant_idx;
                out_valid_reg <= 1'b1;
                if (mode) begin
                    ptr_reg <= ptr_next;
                end
            end else begin
                // Nothing to load: the register empties and keeps its last
                // data/channel.
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_ch    = out_ch_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Directed, table-driven bench for mux_nto1_stream. A 16-channel instance is
// the main target. A 12-channel instance shares the lower inputs so that an
// out-of-range fixed select can be exercised.

module tb_mux_nto1_stream;

    logic           clk;
    logic           rst_n;
    logic [127:0]   in_data;
    logic [15:0]    in_valid;
    logic [15:0]    in_ready;
    logic           mode;
    logic [3:0]     sel;
    logic [7:0]     out_data;
    logic [3:0]     out_ch;
    logic           out_valid;
    logic           out_ready;

    logic [11:0]    in_ready12;
    logic [7:0]     out_data12;
    logic [3:0]     out_ch12;
    logic           out_valid12;

    int checks = 0;
    int errors = 0;

    mux_nto1_stream #(.N(16), .W(8), .SEL_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux_nto1_stream #(.N(12), .W(8), .SEL_W(4)) dut12 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data[95:0]),
        .in_valid  (in_valid[11:0]),
        .in_ready  (in_ready12),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data12),
        .out_ch    (out_ch12),
        .out_valid (out_valid12),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [3:0]  sel;
        logic [15:0] valid;
        logic        ordy;
        logic [15:0] exp_rdy;
        logic        exp_vld;
        logic [7:0]  exp_data;
        logic [3:0]  exp_ch;
        logic [11:0] exp_rdy12;
        logic        exp_vld12;
        logic [7:0]  exp_data12;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Channel c carries 8'hA2 + c, so channel 3 carries 8'hA5.
    task automatic load_default_data();
        for (int c = 0; c < 16; c++) begin
            in_data[c*8 +: 8] = 8'(8'hA2 + c);
        end
    endtask

    task automatic apply_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        @(negedge clk);
        mode      = v.mode;
        sel       = v.sel;
        in_valid  = v.valid;
        out_ready = v.ordy;
        #1;
        check($sformatf("vec%0d in_ready", idx), 32'(in_ready), 32'(v.exp_rdy));
        check($sformatf("vec%0d in_ready12", idx), 32'(in_ready12), 32'(v.exp_rdy12));
        @(posedge clk);
        #1;
        check($sformatf("vec%0d out_valid", idx), 32'(out_valid), 32'(v.exp_vld));
        check($sformatf("vec%0d out_data", idx), 32'(out_data), 32'(v.exp_data));
        check($sformatf("vec%0d out_ch", idx), 32'(out_ch), 32'(v.exp_ch));
        check($sformatf("vec%0d out_valid12", idx), 32'(out_valid12), 32'(v.exp_vld12));
        check($sformatf("vec%0d out_data12", idx), 32'(out_data12), 32'(v.exp_data12));
        $display("vec %0d: mode=%0d sel=%0d valid=%h ordy=%0d | in_ready=%h out_valid=%0d out_data=%h out_ch=%0d | n12 in_ready=%h out_valid=%0d out_data=%h",
                 idx, v.mode, v.sel, v.valid, v.ordy, in_ready, out_valid, out_data, out_ch,
                 in_ready12, out_valid12, out_data12);
    endtask

    initial begin
        //            mode sel    valid     ordy exp_rdy   vld data   ch     rdy12    vld12 data12
        // fixed-mode stream on channel 5
        vecs[0]  = '{1'b0, 4'd5,  16'h0020, 1'b1, 16'h0020, 1'b1, 8'hA7, 4'd5,  12'h020, 1'b1, 8'hA7};
        vecs[1]  = '{1'b0, 4'd5,  16'h0020, 1'b1, 16'h0020, 1'b1, 8'hA7, 4'd5,  12'h020, 1'b1, 8'hA7};
        vecs[2]  = '{1'b0, 4'd5,  16'h0020, 1'b1, 16'h0020, 1'b1, 8'hA7, 4'd5,  12'h020, 1'b1, 8'hA7};
        // sel=15: valid on 16 channels, out of range on 12 channels
        vecs[3]  = '{1'b0, 4'hF,  16'hFFFF, 1'b1, 16'h8000, 1'b1, 8'hB1, 4'd15, 12'h000, 1'b0, 8'hA7};
        vecs[4]  = '{1'b0, 4'hF,  16'h0020, 1'b1, 16'h0000, 1'b0, 8'hB1, 4'd15, 12'h000, 1'b0, 8'hA7};
        vecs[5]  = '{1'b0, 4'd2,  16'h0004, 1'b1, 16'h0004, 1'b1, 8'hA4, 4'd2,  12'h004, 1'b1, 8'hA4};
        // round-robin over 1, 6, 15 (12-ch instance sees only 1 and 6)
        vecs[6]  = '{1'b1, 4'd0,  16'h8042, 1'b1, 16'h0002, 1'b1, 8'hA3, 4'd1,  12'h002, 1'b1, 8'hA3};
        vecs[7]  = '{1'b1, 4'd0,  16'h8042, 1'b1, 16'h0040, 1'b1, 8'hA8, 4'd6,  12'h040, 1'b1, 8'hA8};
        vecs[8]  = '{1'b1, 4'd0,  16'h8042, 1'b1, 16'h8000, 1'b1, 8'hB1, 4'd15, 12'h002, 1'b1, 8'hA3};
        vecs[9]  = '{1'b1, 4'd0,  16'h8042, 1'b1, 16'h0002, 1'b1, 8'hA3, 4'd1,  12'h040, 1'b1, 8'hA8};
        vecs[10] = '{1'b1, 4'd0,  16'h8042, 1'b1, 16'h0040, 1'b1, 8'hA8, 4'd6,  12'h002, 1'b1, 8'hA3};
        vecs[11] = '{1'b1, 4'd0,  16'h8042, 1'b1, 16'h8000, 1'b1, 8'hB1, 4'd15, 12'h040, 1'b1, 8'hA8};
        // sparse round-robin: move ptr to 7, then wrap to channel 0
        vecs[12] = '{1'b1, 4'd0,  16'h0040, 1'b1, 16'h0040, 1'b1, 8'hA8, 4'd6,  12'h040, 1'b1, 8'hA8};
        vecs[13] = '{1'b1, 4'd0,  16'h0001, 1'b1, 16'h0001, 1'b1, 8'hA2, 4'd0,  12'h001, 1'b1, 8'hA2};
        // ptr is now 1, so channel 1 wins over channel 0
        vecs[14] = '{1'b1, 4'd0,  16'h0003, 1'b1, 16'h0002, 1'b1, 8'hA3, 4'd1,  12'h002, 1'b1, 8'hA3};
        vecs[15] = '{1'b1, 4'd0,  16'h0000, 1'b1, 16'h0000, 1'b0, 8'hA3, 4'd1,  12'h000, 1'b0, 8'hA3};
        // fixed-mode grant leaves ptr at 2, so round-robin then wraps to channel 0
        vecs[16] = '{1'b0, 4'd0,  16'h0001, 1'b1, 16'h0001, 1'b1, 8'hA2, 4'd0,  12'h001, 1'b1, 8'hA2};
        vecs[17] = '{1'b1, 4'd0,  16'h0003, 1'b1, 16'h0001, 1'b1, 8'hA2, 4'd0,  12'h001, 1'b1, 8'hA2};
        // ptr 1 -> channel 4 wins over 6, ptr becomes 5
        vecs[18] = '{1'b1, 4'd0,  16'h0050, 1'b1, 16'h0010, 1'b1, 8'hA6, 4'd4,  12'h010, 1'b1, 8'hA6};

        // ---------------- reset with every channel valid ----------------
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = 4'd3;
        in_valid  = 16'hFFFF;
        out_ready = 1'b1;
        load_default_data();
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset out_ch", 32'(out_ch), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset in_ready12", 32'(in_ready12), 32'd0);
        $display("reset: out_valid=%0d out_data=%h out_ch=%0d in_ready=%h", out_valid, out_data, out_ch, in_ready);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release in_ready", 32'(in_ready), 32'h0008);
        @(posedge clk);
        #1;
        check("first out_valid", 32'(out_valid), 32'd1);
        check("first out_data", 32'(out_data), 32'hA5);
        check("first out_ch", 32'(out_ch), 32'd3);
        $display("first word: out_valid=%0d out_data=%h out_ch=%0d", out_valid, out_data, out_ch);

        // ---------------- fixed mode and out-of-range select ----------------
        for (int i = 0; i <= 5; i++) apply_vec(i);

        // ---------------- back-pressure on channel 2 ----------------
        // Output holds A4 from channel 2. Channel 2 now offers a new word 42.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_data[2*8 +: 8] = 8'h42;
            in_valid  = 16'h0004;
            out_ready = 1'b0;
            #1;
            check($sformatf("stall%0d in_ready", k), 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("stall%0d out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d out_data", k), 32'(out_data), 32'hA4);
            check($sformatf("stall%0d out_ch", k), 32'(out_ch), 32'd2);
            $display("stall %0d: in_ready=%h out_valid=%0d out_data=%h out_ch=%0d", k, in_ready, out_valid, out_data, out_ch);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("unstall in_ready", 32'(in_ready), 32'h0004);
        @(posedge clk);
        #1;
        check("unstall out_valid", 32'(out_valid), 32'd1);
        check("unstall out_data", 32'(out_data), 32'h42);
        check("unstall out_ch", 32'(out_ch), 32'd2);
        $display("unstall: out_valid=%0d out_data=%h out_ch=%0d", out_valid, out_data, out_ch);
        @(negedge clk);
        load_default_data();

        // ---------------- round-robin, sparse, mode change ----------------
        for (int i = 6; i <= 18; i++) apply_vec(i);

        // ---------------- async reset during a stall ----------------
        @(negedge clk);
        in_valid  = 16'h0050;
        out_ready = 1'b0;
        #1;
        check("pre-reset stall in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("pre-reset stall out_valid", 32'(out_valid), 32'd1);
        check("pre-reset stall out_data", 32'(out_data), 32'hA6);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 32'(out_valid), 32'd0);
        check("async reset out_data", 32'(out_data), 32'd0);
        check("async reset out_ch", 32'(out_ch), 32'd0);
        check("async reset in_ready", 32'(in_ready), 32'd0);
        check("async reset out_valid12", 32'(out_valid12), 32'd0);
        $display("async reset: out_valid=%0d out_data=%h out_ch=%0d in_ready=%h", out_valid, out_data, out_ch, in_ready);

        @(negedge clk);
        rst_n = 1'b1;
        mode  = 1'b1;
        #1;
        // ptr back at 0: channel 4 is the lowest requester
        check("post-reset in_ready", 32'(in_ready), 32'h0010);
        @(posedge clk);
        #1;
        check("post-reset out_valid", 32'(out_valid), 32'd1);
        check("post-reset out_data", 32'(out_data), 32'hA6);
        check("post-reset out_ch", 32'(out_ch), 32'd4);
        $display("post-reset: out_valid=%0d out_data=%h out_ch=%0d", out_valid, out_data, out_ch);

        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("post-reset 2nd in_ready", 32'(in_ready), 32'h0040);
        @(posedge clk);
        #1;
        check("post-reset 2nd out_data", 32'(out_data), 32'hA8);
        check("post-reset 2nd out_ch", 32'(out_ch), 32'd6);
        $display("post-reset 2nd: out_valid=%0d out_data=%h out_ch=%0d", out_valid, out_data, out_ch);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
